// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU writeback slice.
//   - FPU op codes as seen by the decoder (8..B).
//   - reg_idx_t: architectural register index.
//   - fpu_wb_entry_t: one buffered FPU result {dest, data}.
package fpu_pkg;

    localparam logic [3:0] FPU_OP_ADD = 4'h8;
    localparam logic [3:0] FPU_OP_SUB = 4'h9;
    localparam logic [3:0] FPU_OP_MUL = 4'hA;
    localparam logic [3:0] FPU_OP_DIV = 4'hB;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t    dest;
        logic [31:0] data;
    } fpu_wb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// fpu_wb_fifo: synchronous FIFO of fpu_wb_entry_t.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   push, push_data - write request and entry; a push while full is only
//                   taken when a pop happens in the same cycle, else dropped
//   pop           - remove the head (ignored when empty)
//   head          - current head entry (valid when not empty)
//   count, full, empty - occupancy status
// Pointers carry one extra bit so full and empty are distinguishable.
module fpu_wb_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  fpu_wb_entry_t             push_data,
    input  logic                      pop,
    output fpu_wb_entry_t             head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    fpu_wb_entry_t mem_q [DEPTH];
    ptr_t          wr_ptr_q, wr_ptr_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (count == ptr_t'(DEPTH));
        rd_en    = pop & ~empty;
        // A full FIFO still accepts a push when the head leaves this cycle.
        wr_en    = push & (~full | rd_en);
        wr_ptr_d = wr_ptr_q + ptr_t'(wr_en);
        rd_ptr_d = rd_ptr_q + ptr_t'(rd_en);
        head     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fpu_writeback.sv
// fpu_writeback: buffers FPU results and writes them to the register file
// port shared with the integer pipeline (integer side always wins).
// Tracks a per-register busy scoreboard and an outstanding-op limit.
// Ports:
//   clock, reset              - rising-edge clock, async active-high reset
//   issue_valid/issue_dest    - FPU op issued by the decoder
//   issue_ready               - issue allowed (outstanding < DEPTH)
//   fpu_valid/fpu_dest/fpu_result - FPU result stream
//   cpu_wb_valid              - integer pipeline owns the write port
//   wb_valid/wb_dest/wb_data  - FPU register-file write
//   busy_mask                 - bit r set: FPU write to r pending
//   overflow                  - sticky: result arrived with FIFO full
// Optional macro FPU_WB_BYPASS_EN: a result arriving to an empty FIFO with
// the port free is written back in the same cycle instead of being queued.
module fpu_writeback
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dest,
    output logic        issue_ready,
    input  logic        fpu_valid,
    input  logic [4:0]  fpu_dest,
    input  logic [31:0] fpu_result,
    input  logic        cpu_wb_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic [31:0] busy_mask,
    output logic        overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic [31:0]          busy_q, busy_d;
    logic                 overflow_q, overflow_d;

    fpu_wb_entry_t        push_entry;
    fpu_wb_entry_t        fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 bypass;
    logic                 issue_acc;

    fpu_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        push_entry = '{dest: fpu_dest, data: fpu_result};

        bypass = 1'b0;
`ifdef FPU_WB_BYPASS_EN
        bypass = fifo_empty & ~cpu_wb_valid & fpu_valid;
`endif

        fifo_pop  = (fifo_count != '0) & ~cpu_wb_valid;
        fifo_push = fpu_valid & ~bypass;

        wb_valid = fifo_pop | bypass;
        wb_dest  = '0;
        wb_data  = '0;
        if (fifo_pop) begin
            wb_dest = fifo_head.dest;
            wb_data = fifo_head.data;
        end else if (bypass) begin
            wb_dest = fpu_dest;
            wb_data = fpu_result;
        end

        issue_ready = (outstanding_q < CW'(DEPTH));
        issue_acc   = issue_valid & issue_ready;

        outstanding_d = outstanding_q + CW'(issue_acc) - CW'(wb_valid);

        // Clear before set so a same-register set/clear leaves the bit set.
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_dest] = 1'b0;
        end
        if (issue_acc && (issue_dest != '0)) begin
            busy_d[issue_dest] = 1'b1;
        end

        overflow_d = overflow_q | (fifo_push & fifo_full & ~fifo_pop);

        busy_mask = busy_q;
        overflow  = overflow_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
            busy_q        <= '0;
            overflow_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            busy_q        <= busy_d;
            overflow_q    <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fpu_writeback.sv
// Testbench for fpu_writeback: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_fpu_writeback;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_dest = '0;
    logic        issue_ready;
    logic        fpu_valid = 1'b0;
    logic [4:0]  fpu_dest = '0;
    logic [31:0] fpu_result = '0;
    logic        cpu_wb_valid = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic [31:0] busy_mask;
    logic        overflow;

    fpu_writeback #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .issue_ready  (issue_ready),
        .fpu_valid    (fpu_valid),
        .fpu_dest     (fpu_dest),
        .fpu_result   (fpu_result),
        .cpu_wb_valid (cpu_wb_valid),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .busy_mask    (busy_mask),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_out;
    logic [31:0] m_busy;
    logic        m_ovf;
    logic [4:0]  qd[$];
    logic [31:0] qv[$];
    logic [4:0]  pend[$];   // issued ops the FPU has not yet returned

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_out  = 0;
        m_busy = '0;
        m_ovf  = 1'b0;
        qd.delete();
        qv.delete();
        pend.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        issue_valid = 0; issue_dest = 0; fpu_valid = 0; fpu_dest = 0;
        fpu_result = 0; cpu_wb_valid = 0;
        #2 reset = 1'b1;
        #1;
        check("rst_busy", busy_mask, 32'h0);
        check("rst_ready", {31'h0, issue_ready}, 32'h1);
        check("rst_wbv", {31'h0, wb_valid}, 32'h0);
        check("rst_dest", {27'h0, wb_dest}, 32'h0);
        check("rst_data", wb_data, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // then advance the model to reflect the coming rising edge.
    task automatic step(input logic iv, input logic [4:0] id, input logic fv,
                        input logic [4:0] fd, input logic [31:0] fr, input logic cpu);
        logic        byp;
        logic        e_wbv;
        logic [4:0]  e_dest;
        logic [31:0] e_data;
        logic        e_rdy;
        logic        acc;
        @(negedge clock);
        issue_valid = iv; issue_dest = id; fpu_valid = fv; fpu_dest = fd;
        fpu_result = fr; cpu_wb_valid = cpu;
        #1;
        byp = 1'b0;
`ifdef FPU_WB_BYPASS_EN
        byp = (qd.size() == 0) && !cpu && fv;
`endif
        e_wbv = 0; e_dest = 0; e_data = 0;
        if (qd.size() > 0 && !cpu) begin
            e_wbv = 1; e_dest = qd[0]; e_data = qv[0];
        end else if (byp) begin
            e_wbv = 1; e_dest = fd; e_data = fr;
        end
        e_rdy = (m_out < DEPTH);
        check("wb_valid", {31'h0, wb_valid}, {31'h0, e_wbv});
        check("wb_dest", {27'h0, wb_dest}, {27'h0, e_dest});
        check("wb_data", wb_data, e_data);
        check("issue_ready", {31'h0, issue_ready}, {31'h0, e_rdy});
        check("busy_mask", busy_mask, m_busy);
        check("overflow", {31'h0, overflow}, {31'h0, m_ovf});

        acc = iv && e_rdy;
        if (e_wbv && !byp) begin
            void'(qd.pop_front());
            void'(qv.pop_front());
        end
        m_out = m_out + int'(acc) - int'(e_wbv);
        if (e_wbv) m_busy[e_dest] = 1'b0;
        if (acc && id != 0) m_busy[id] = 1'b1;
        if (fv && !byp) begin
            if (qd.size() < DEPTH) begin
                qd.push_back(fd);
                qv.push_back(fr);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic cpu);
        step(0, 0, 0, 0, 0, cpu);
    endtask

    initial begin
        model_clear();
        do_reset();

        // Reset mid-traffic
        step(1, 3, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0);
        step(0, 0, 1, 3, 32'h3F800000, 1);
        idle(1);
        do_reset();

        // Single op
        step(1, 5, 0, 0, 0, 0);
        step(0, 0, 1, 5, 32'h40490FDB, 0);
        check("single_busy_set", {31'h0, busy_mask[5]}, 32'h1);
`ifdef FPU_WB_BYPASS_EN
        check("single_wb_n", {31'h0, wb_valid}, 32'h1);
        check("single_data_n", wb_data, 32'h40490FDB);
        idle(0);
`else
        check("single_wb_n", {31'h0, wb_valid}, 32'h0);
        idle(0);
        check("single_wb_n1", {31'h0, wb_valid}, 32'h1);
        check("single_dest_n1", {27'h0, wb_dest}, 32'h5);
        check("single_data_n1", wb_data, 32'h40490FDB);
`endif
        idle(0);
        check("single_busy_clr", {31'h0, busy_mask[5]}, 32'h0);

        // Port conflict
        step(1, 1, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h11111111, 1);
        step(0, 0, 1, 2, 32'h22222222, 1);
        idle(1);
        idle(1);
        check("conflict_hold", {31'h0, wb_valid}, 32'h0);
        idle(0);
        check("conflict_r1", {27'h0, wb_dest}, 32'h1);
        idle(0);
        check("conflict_r2", {27'h0, wb_dest}, 32'h2);
        idle(0);

        // Issue limit
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 5'(i), 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 0);
        check("limit_ready", {31'h0, issue_ready}, 32'h0);
        idle(0);
        check("limit_ignored", {31'h0, busy_mask[5]}, 32'h0);
        step(0, 0, 1, 1, 32'hAAAA0001, 0);
        idle(0);
        idle(0);
        check("limit_reraise", {31'h0, issue_ready}, 32'h1);

        // Same-cycle set/clear on r7
        do_reset();
        step(1, 7, 0, 0, 0, 0);
        step(0, 0, 1, 7, 32'h77777777, 1);
        step(1, 7, 0, 0, 0, 0);
        check("setclr_wb", {27'h0, wb_dest}, 32'h7);
        idle(0);
        check("setclr_busy", {31'h0, busy_mask[7]}, 32'h1);

        // Overflow
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 5'(i), 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 0, 1, 5'((i - 1) % 4 + 1), 32'hF0000000 + 32'(i), 1);
        idle(1);
        check("ovf_set", {31'h0, overflow}, 32'h1);
        for (int i = 0; i < 4; i++) idle(0);
        idle(0);
        check("ovf_drop", {31'h0, wb_valid}, 32'h0);
        check("ovf_sticky", {31'h0, overflow}, 32'h1);
        do_reset();

        // Randomized traffic honouring the issue limit and WAW guard
        for (int n = 0; n < 3000; n++) begin
            logic        iv, fv, cpu, acc;
            logic [4:0]  id, fd;
            iv = 0; id = 0; fv = 0; fd = 0;
            if ($urandom_range(0, 2) != 0) begin
                id = 5'($urandom_range(0, 31));
                if (!m_busy[id]) iv = 1;
            end
            acc = iv && (m_out < DEPTH);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                int k;
                k = $urandom_range(0, pend.size() - 1);
                fd = pend[k];
                pend.delete(k);
                fv = 1;
            end
            cpu = ($urandom_range(0, 3) == 0);
            step(iv, id, fv, fd, $urandom, cpu);
            if (acc) pend.push_back(id);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpu_writeback.md
Name: fpu_writeback

Overview:
- Sits directly downstream of the FPU; consumes its fpu_valid/fpu_dest/fpu_result stream.
- Buffers results in a small FIFO and arbitrates them onto the register-file write port shared with the integer pipeline. The integer pipeline always has priority.
- Keeps a per-register scoreboard (busy mask) and an outstanding-op limit, so the decoder can stall FPU issue and dependent reads.

Parameters:
- DEPTH, 4, FIFO entries; also the maximum number of FPU ops outstanding (issued but not yet written back). Power of two, 2..16.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  decoder issues an FPU op (fpu_op 8..B) this cycle
- issue_dest  in  5  destination register of the issued op
- issue_ready  out  1  FPU issue permitted this cycle
- fpu_valid  in  1  FPU result strobe
- fpu_dest  in  5  destination of the FPU result
- fpu_result  in  32  IEEE-754 single result
- cpu_wb_valid  in  1  integer pipeline owns the write port this cycle
- wb_valid  out  1  FPU write to the register file this cycle
- wb_dest  out  5  write address
- wb_data  out  32  write data
- busy_mask  out  32  bit r set = register r has an FPU write pending
- overflow  out  1  sticky error: a result arrived with the FIFO full

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - FIFO emptied; outstanding = 0; busy_mask = 0; overflow = 0.
  - wb_valid = 0; wb_dest = 0; wb_data = 0; issue_ready = 1 once out of reset.
  - In-flight FPU results arriving after reset deasserts are still accepted. The FPU is reset together with this block, so none arrive.
- Outstanding counter, width clog2(DEPTH)+1:
  - +1 on an accepted issue (issue_valid & issue_ready).
  - -1 on each wb_valid cycle.
  - Both in the same cycle: unchanged.
- issue_ready = (outstanding < DEPTH), combinational from registered state.
  - issue_valid while issue_ready = 0 is ignored: no count change, no busy set.
- Dest 0 (hardwired zero register):
  - An issue to r0 counts as outstanding but never sets busy.
  - Its result is popped as normal with wb_valid = 1 and wb_dest = 0; the register file ignores the write.
- Scoreboard:
  - busy[issue_dest] set on an accepted issue.
  - busy[wb_dest] cleared on a wb_valid cycle.
  - Same-register set and clear in the same cycle: set wins.
  - The decoder must not issue to a busy dest. This is a WAW guard and is not checked here.
- FIFO push: fpu_valid pushes {fpu_dest, fpu_result} at the clock edge.
  - Push when full: the data is dropped and overflow is set (sticky). This is unreachable when the issue limit is honoured.
- FIFO pop: when not empty and cpu_wb_valid = 0, the head is presented and popped.
  - wb_valid, wb_dest and wb_data are driven combinationally from the head and gated by ~cpu_wb_valid.
  - Pop happens the same cycle as the push of a new entry is allowed (simultaneous push/pop when full is legal: count unchanged).
- cpu_wb_valid = 1: wb_valid = 0 and the FIFO holds.
  - Unbounded integer priority can starve the FPU. This is accepted; the integer pipeline leaves bubbles.
- Latency: fpu_valid at cycle N gives wb_valid at N+1 at the earliest (FIFO registered).
- Ordering: results are written back in arrival order. FPU units may complete out of issue order; this is harmless given the WAW guard.
- Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.

Optional Feature:
- Macro: FPU_WB_BYPASS_EN.
- Defined: when the FIFO is empty, cpu_wb_valid = 0 and fpu_valid = 1, the result drives wb_* in cycle N (zero latency) and is not pushed. The busy clear and outstanding decrement happen in that cycle.
- Undefined: every result goes through the FIFO, giving a minimum latency of 1 cycle.

Decomposition:
- Shared package fpu_pkg:
  - Op codes FPU_OP_ADD = 4'h8, FPU_OP_SUB = 4'h9, FPU_OP_MUL = 4'hA, FPU_OP_DIV = 4'hB.
  - Typedef reg_idx_t (5 bits).
  - Packed struct fpu_wb_entry_t {reg_idx_t dest; logic [31:0] data}.
- One sub-module: fpu_wb_fifo, a generic synchronous FIFO of fpu_wb_entry_t with count, full and empty outputs. The arbitration, scoreboard and counter stay in the top module.

Test Plan:
- Reset mid-traffic:
  - Stimulus: issue r3 and r4, assert reset.
  - Required response: busy_mask = 0, outstanding = 0, issue_ready = 1, wb_valid = 0.
- Single op:
  - Stimulus: issue r5, then fpu_valid with dest 5, result 32'h40490FDB at cycle 10.
  - Required response: wb_valid at cycle 11 with wb_dest = 5 and wb_data = 32'h40490FDB; busy_mask[5] goes 1 then 0 after cycle 11. With FPU_WB_BYPASS_EN, wb_valid is at cycle 10.
- Port conflict:
  - Stimulus: cpu_wb_valid held high for cycles 10..13 while results for r1 and r2 arrive at cycles 10 and 11.
  - Required response: wb_valid = 0 through cycle 13; r1 written at cycle 14, r2 at cycle 15.
- Issue limit (DEPTH = 4):
  - Stimulus: issue r1..r4 with no results.
  - Required response: issue_ready = 0; a 5th issue_valid is ignored. One writeback re-raises issue_ready in the following cycle.
- Same-cycle set/clear:
  - Stimulus: writeback of r7 coincides with an accepted issue to r7.
  - Required response: busy_mask[7] = 1 afterwards.
- Overflow:
  - Stimulus: force 5 fpu_valid pulses with cpu_wb_valid = 1 and DEPTH = 4.
  - Required response: overflow = 1 and stays 1 until reset; the 5th entry is discarded.
